// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and elaboration helpers for the synchronous FIFO
// Contents: default width/depth, constant clog2, parameter legality predicate.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // DEPTH must be a power of two >= 2; thresholds must be reachable counts.
  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af_level, input int ae_level);
    bit ok;
    ok = (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    ok = ok && (af_level >= 1) && (af_level <= depth);
    ok = ok && (ae_level >= 0) && (ae_level <= depth - 1);
    return ok;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
// Ports: clk, we, waddr, wdata (write port); raddr -> rdata (combinational read).
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = fifo_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; occupancy is tracked by the pointers.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with flags, flush and FWFT mode
// Ports: clk, rst_n (async low); wr/rd/flush/clr_err controls; data_in -> data_out;
//        fifo_full/empty/almost_full/almost_empty status, sticky fifo_overflow/underflow,
//        fifo_count occupancy 0..DEPTH.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic                          rd,
  input  logic                          flush,
  input  logic                          clr_err,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow,
  output logic [fifo_clog2(DEPTH):0]    fifo_count
);

  localparam int ADDR_W = fifo_clog2(DEPTH);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("fifo_sync_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_rej;
  logic              rd_rej;

  assign fifo_count        = wr_ptr - rd_ptr;
  assign fifo_full         = (fifo_count == DEPTH_C);
  assign fifo_empty        = (fifo_count == '0);
  assign fifo_almost_full  = (fifo_count >= AF_C);
  assign fifo_almost_empty = (fifo_count <= AE_C);

  // Full/empty are judged on pre-edge state, so a same-cycle pop never frees room
  // for a write and a same-cycle push never supplies a read.
  assign wr_ok  = wr && !fifo_full  && !flush;
  assign rd_ok  = rd && !fifo_empty && !flush;
  assign wr_rej = wr && fifo_full   && !flush;
  assign rd_rej = rd && fifo_empty  && !flush;

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      // A fresh rejection outranks a simultaneous clear.
      if (wr_rej)       fifo_overflow <= 1'b1;
      else if (clr_err) fifo_overflow <= 1'b0;
      if (rd_rej)       fifo_underflow <= 1'b1;
      else if (clr_err) fifo_underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is shown directly; nothing to register.
    assign data_out = fifo_empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (flush) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= ram_rdata;
      end
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - scoreboard bench for fifo_sync_param in both read modes
module tb_fifo_sync_param;

  logic       clk;
  logic       rst_n;
  logic       wr, rd, flush, clr_err;
  logic [7:0] data_in;

  logic [7:0] d0, d1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(d0), .fifo_full(full0), .fifo_empty(empty0),
    .fifo_almost_full(af0), .fifo_almost_empty(ae0), .fifo_overflow(ovf0),
    .fifo_underflow(unf0), .fifo_count(cnt0)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(d1), .fifo_full(full1), .fifo_empty(empty1),
    .fifo_almost_full(af1), .fifo_almost_empty(ae1), .fifo_overflow(ovf1),
    .fifo_underflow(unf1), .fifo_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         count;
    bit         ovf;
    bit         unf;
    logic [7:0] d_std;
    logic [7:0] d_fwft;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_dstd;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Status expectations come straight from occupancy rules, applied to both instances.
  task automatic chk_status(input exp_t e);
    chk("count_std",  32'(cnt0),  32'(e.count));
    chk("count_fwft", 32'(cnt1),  32'(e.count));
    chk("full",       32'({full0, full1}),   {30'd0, {2{e.count == 16}}});
    chk("empty",      32'({empty0, empty1}), {30'd0, {2{e.count == 0}}});
    chk("almost_full",  32'({af0, af1}), {30'd0, {2{e.count >= 14}}});
    chk("almost_empty", 32'({ae0, ae1}), {30'd0, {2{e.count <= 2}}});
    chk("overflow",   32'({ovf0, ovf1}), {30'd0, {2{e.ovf}}});
    chk("underflow",  32'({unf0, unf1}), {30'd0, {2{e.unf}}});
    chk("data_std",   32'(d0), 32'(e.d_std));
    chk("data_fwft",  32'(d1), 32'(e.d_fwft));
  endtask

  // Monitor: every edge that has a pending expectation is checked 1 ns later.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_status(e);
    end
  end

  function automatic exp_t snapshot();
    exp_t e;
    e.count  = mq.size();
    e.ovf    = m_ovf;
    e.unf    = m_unf;
    e.d_std  = m_dstd;
    e.d_fwft = (mq.size() > 0) ? mq[0] : 8'h00;
    return e;
  endfunction

  // Drive one cycle of stimulus and predict the state after the next rising edge.
  task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [7:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    wr = w; rd = r; flush = f; clr_err = c; data_in = d;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    if (f) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dstd = 8'h00;
    end else begin
      if (w && was_full) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      if (r && was_empty) m_unf = 1'b1;
      else if (c)         m_unf = 1'b0;
      if (r && !was_empty) m_dstd = mq.pop_front();
      if (w && !was_full)  mq.push_back(d);
    end
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dstd = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk_status(snapshot());
    rst_n = 1'b1;

    // Basic in-order transfer.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();

    // Fill, reject a write, drain.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 127)));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Underflow and clear semantics.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous wr+rd at 15 and at full.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Random walk across several pointer wraps, crossing both thresholds.
    for (int i = 0; i < 240; i++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < ((i / 40) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 40) % 2 == 0 ? 35 : 70));
      step(w, r, 1'b0, 1'b0, 8'($urandom));
    end

    // Fall-through of a single word, then flush while writing.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    idle();

    // Fully random traffic including flush and clr_err.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, 8'($urandom));
    end

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    drain();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_status(snapshot());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hE0 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO, successor to the fixed 8-bit FIFO memory unit. Adds configurable data width and depth, programmable almost-full/almost-empty levels, an occupancy count, sticky error flags with clear, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in the same clock domain.

## Interface
- DATA_W, 8: data word width in bits (≥1).
- DEPTH, 16: number of entries; power of two, ≥2. ADDR_W = log2(DEPTH).
- AF_LEVEL, DEPTH-2: fifo_almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: fifo_almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr  in  1  write request.
- rd  in  1  read request (pop in FWFT mode).
- flush  in  1  synchronous clear of contents and error flags.
- clr_err  in  1  synchronous clear of sticky overflow/underflow.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_almost_full  out  1  count ≥ AF_LEVEL.
- fifo_almost_empty  out  1  count ≤ AE_LEVEL.
- fifo_overflow  out  1  sticky: a write was rejected.
- fifo_underflow  out  1  sticky: a read was rejected.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_W+1 bits (MSB = wrap bit); fifo_count = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1). Pointer increments wrap naturally; no special-casing at DEPTH−1.
- Write accepted iff wr && !fifo_full && !flush: mem[wr_ptr[ADDR_W-1:0]] ← data_in, wr_ptr+1.
- Read accepted iff rd && !fifo_empty && !flush: rd_ptr+1.
- Full is evaluated before the edge: wr while full is rejected even if rd is also accepted in that cycle. Empty likewise: rd while empty is rejected even if wr is accepted.
- rd && wr, neither rejected: both performed, count unchanged.
- Rejected write sets fifo_overflow; rejected read sets fifo_underflow. Memory and pointers are untouched.
- Sticky flags hold until clr_err, flush, or reset. If a new rejection coincides with clr_err, the set wins.
- flush has priority over wr, rd and clr_err. It zeroes both pointers, clears both sticky flags, and drives data_out to 0. Concurrent wr/rd are ignored and flag no error.
- FWFT=0: on an accepted read, data_out ← head word (registered). Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] when !fifo_empty, else 0. rd acknowledges/pops the displayed word.
- Memory contents are not reset.

## Timing
- Reset (async assert, sync-safe deassert by the environment): pointers 0, fifo_count 0, fifo_empty 1, fifo_almost_empty 1, fifo_full 0, fifo_almost_full 0, fifo_overflow 0, fifo_underflow 0, data_out 0.
- Reset mid-operation aborts immediately; all contents are discarded.
- Status outputs are combinational from registered pointers and reflect each edge's update in the same cycle after that edge (0-cycle lag from state).
- FWFT=0 read latency: data_out valid 1 cycle after the rd edge.
- FWFT=1: the first written word appears on data_out in the cycle after its write edge.
- Write-to-nonempty: fifo_empty deasserts after the first accepted write edge.

## Structure
- Shared package/header fifo_pkg: the clog2 function, default DATA_W/DEPTH constants, and parameter-legality checks (DEPTH power of two; AF_LEVEL/AE_LEVEL in range) reported at elaboration.
- Sub-module fifo_ram_dp: DEPTH×DATA_W storage with a synchronous write port and an asynchronous read port. Pointer, flag, and output logic stay in fifo_sync_param.

## Test plan
- DEPTH=16, FWFT=0: write 0x01..0x05, then 5 reads → data_out 0x01..0x05, each one cycle after rd. Count goes 5→0, fifo_empty=1 at the end.
- Fill 16 entries, then wr=1 with 0xAA → fifo_full=1, fifo_overflow=1, count stays 16. Read back 16 words; 0xAA is absent.
- From empty, rd=1 → fifo_underflow=1, data_out unchanged. clr_err alone clears it; clr_err together with a second rejected rd leaves it at 1.
- Count at 15 with wr+rd same cycle → count stays 15. At full with wr+rd → read taken, write rejected, count 15, overflow set.
- Wrap: 40 writes interleaved with 40 reads (≥2 pointer wraps) → in-order data, and almost_full/almost_empty toggle exactly at count 14 and 2.
- FWFT=1: write 0x3C → data_out=0x3C the next cycle without rd. Flush with wr=1 → count 0, data_out 0, flags cleared, no overflow.
